drive_mode_ctrl_p: RTL and testbench
====================================

# drive_mode_ctrl_p

Parametrised vehicle drive-mode controller: a second-generation mode FSM with multi-bit speed, configurable thresholds with cruise hysteresis, and a debounced obstacle input. It adds an emergency hold timer, reverse and park requests, and a saturating emergency-event counter. It sits between the speed/obstacle sensor front-end and the actuator drivers, producing Moore-decoded accelerate/brake/reverse commands plus state and event status for the supervisor.

## Interface
- SPEED_W, 8: speed input width (unsigned).
- DRIVE_TH, 10: speed at or above which START enters DRIVE. Must satisfy 0 < DRIVE_TH < CRUISE_TH.
- CRUISE_TH, 30: speed at or above which DRIVE enters CRUISE.
- HYST, 5: CRUISE falls back to DRIVE when speed < CRUISE_TH-HYST. Must satisfy 0 ≤ HYST < CRUISE_TH.
- OBS_FILT, 3: consecutive sampled-high cycles of obstacle needed to qualify it (≥1).
- EMG_HOLD, 16: emergency hold count (≥1).
- CNT_W, 8: emergency event counter width.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed.
- speed  in  SPEED_W  current speed, unsigned.
- obstacle  in  1  raw obstacle flag.
- reverse_req  in  1  driver requests reverse.
- park_req  in  1  driver requests park.
- accelerate  out  1  high in DRIVE, CRUISE.
- brake  out  1  high in PARK, EMERGENCY.
- reverse_en  out  1  high in REVERSE.
- state  out  3  current state encoding.
- emergency  out  1  one-cycle pulse, first cycle in EMERGENCY.
- emg_count  out  CNT_W  saturating count of EMERGENCY entries.

## Operation
- States/encoding: IDLE=0, START=1, DRIVE=2, REVERSE=3, CRUISE=4, PARK=5, EMERGENCY=6. Encoding 7 is illegal and goes to IDLE on next edge.
- Obstacle filter: filt_cnt increments on each edge with obstacle=1 and saturates at OBS_FILT-1. It clears on any edge with obstacle=0. obs_valid = obstacle && filt_cnt == OBS_FILT-1 (combinational).
- Transitions are evaluated in the listed order; first match wins; otherwise the state holds:
  - Any state in {START, DRIVE, REVERSE, CRUISE, PARK}, obs_valid: go to EMERGENCY. IDLE ignores obstacle.
  - IDLE: speed>0 -> START.
  - START: reverse_req -> REVERSE; speed≥DRIVE_TH -> DRIVE.
  - DRIVE: speed≥CRUISE_TH -> CRUISE; speed==0 && park_req -> PARK.
  - CRUISE: speed==0 -> PARK; speed<CRUISE_TH-HYST -> DRIVE.
  - REVERSE: speed==0 && !reverse_req -> PARK.
  - PARK: speed>0 && !park_req -> START.
  - EMERGENCY: !obstacle && speed==0 && hold_cnt==0 -> IDLE.
- Hold timer: hold_cnt loads EMG_HOLD on the edge that enters EMERGENCY. On each edge while in EMERGENCY: reload EMG_HOLD if obstacle=1, else decrement if nonzero.
- emg_count increments on each EMERGENCY entry and saturates at 2^CNT_W-1. Saturation does not wrap.
- Outputs decode combinationally from the registered state only (Moore). No input reaches an output combinationally.

## Timing
- Reset: state=IDLE, filt_cnt=0, hold_cnt=0, emg_count=0. accelerate=brake=reverse_en=emergency=0 on the cycle after the reset edge. Reset mid-operation, including in EMERGENCY, overrides all transitions.
- Transition latency: one edge. Outputs change in the same cycle as state.
- Obstacle latency: obstacle high from edge k onward -> state=EMERGENCY after edge k+OBS_FILT-1. With OBS_FILT=1, the first sampling edge triggers it. A one-cycle low anywhere restarts qualification.
- Minimum EMERGENCY dwell: EMG_HOLD+1 cycles. Entered at edge e, with obstacle low and speed 0 thereafter, it exits at edge e+EMG_HOLD+1.
- emergency pulse: high exactly one cycle per entry. EMERGENCY cannot be re-entered without leaving it.
- Simultaneous events: obs_valid beats every other condition. In START, reverse_req beats the speed threshold. In CRUISE, speed==0 beats hysteresis fallback.

## Test plan
- Reset, then speed 0→5→12→35→27→24 (defaults): IDLE→START→DRIVE→CRUISE, stays CRUISE at 27, goes to DRIVE at 24. accelerate=1 in DRIVE/CRUISE.
- In DRIVE, obstacle high 2 cycles then low, then high 3 cycles: no entry on the first burst. EMERGENCY after the 3rd sampled-high edge. emergency pulses once, emg_count=1, brake=1.
- In EMERGENCY, obstacle low, speed 0: exit to IDLE after exactly 17 cycles. A one-cycle obstacle blip mid-hold reloads the timer and adds 17 more cycles.
- START with reverse_req=1 and speed=15 together: REVERSE (reverse_en=1). Then speed 0, reverse_req=0: PARK with brake=1. Then speed 3, park_req=0: START.
- CNT_W=2, force 5 EMERGENCY entries: emg_count reads 1,2,3,3,3.
- Assert reset in CRUISE while obstacle is qualifying: next cycle state=0, all outputs 0, counters 0.

Source files
------------

// File: rtl/drive_mode_ctrl_p_if.sv
// rtl/drive_mode_ctrl_p_if.sv - sensor/driver inputs and actuator/status outputs of the drive-mode controller
interface drive_mode_ctrl_p_if #(
  parameter int SPEED_W = 8,
  parameter int CNT_W   = 8
);
  logic [SPEED_W-1:0] speed;
  logic               obstacle;
  logic               reverse_req;
  logic               park_req;
  logic               accelerate;
  logic               brake;
  logic               reverse_en;
  logic [2:0]         state;
  logic               emergency;
  logic [CNT_W-1:0]   emg_count;

  modport master (
    output speed, obstacle, reverse_req, park_req,
    input  accelerate, brake, reverse_en, state, emergency, emg_count
  );

  modport slave (
    input  speed, obstacle, reverse_req, park_req,
    output accelerate, brake, reverse_en, state, emergency, emg_count
  );
endinterface

// File: rtl/drive_mode_ctrl_p.sv
// rtl/drive_mode_ctrl_p.sv - drive-mode FSM with obstacle filter, emergency hold timer and event counter
module drive_mode_ctrl_p #(
  parameter int SPEED_W   = 8,
  parameter int DRIVE_TH  = 10,
  parameter int CRUISE_TH = 30,
  parameter int HYST      = 5,
  parameter int OBS_FILT  = 3,
  parameter int EMG_HOLD  = 16,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               reset,
  drive_mode_ctrl_p_if.slave bus
);

  localparam int FILT_W = (OBS_FILT > 1) ? $clog2(OBS_FILT) : 1;
  localparam int HOLD_W = $clog2(EMG_HOLD + 1);

  localparam logic [SPEED_W-1:0] DRIVE_TH_V  = SPEED_W'(DRIVE_TH);
  localparam logic [SPEED_W-1:0] CRUISE_TH_V = SPEED_W'(CRUISE_TH);
  localparam logic [SPEED_W-1:0] CRUISE_LO_V = SPEED_W'(CRUISE_TH - HYST);
  localparam logic [FILT_W-1:0]  FILT_MAX    = FILT_W'(OBS_FILT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD   = HOLD_W'(EMG_HOLD);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DRIVE     = 3'd2,
    S_REVERSE   = 3'd3,
    S_CRUISE    = 3'd4,
    S_PARK      = 3'd5,
    S_EMERGENCY = 3'd6
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [FILT_W-1:0] filt_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0]  emg_cnt_q;
  logic              emg_first_q;
  logic              obs_valid;
  logic              speed_zero;
  logic              entering_emg;

  assign obs_valid    = bus.obstacle && (filt_cnt_q == FILT_MAX);
  assign speed_zero   = (bus.speed == '0);
  assign entering_emg = (state_q != S_EMERGENCY) && (state_d == S_EMERGENCY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!speed_zero) state_d = S_START;
      end
      S_START: begin
        if (obs_valid)                     state_d = S_EMERGENCY;
        else if (bus.reverse_req)          state_d = S_REVERSE;
        else if (bus.speed >= DRIVE_TH_V)  state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (obs_valid)                         state_d = S_EMERGENCY;
        else if (bus.speed >= CRUISE_TH_V)     state_d = S_CRUISE;
        else if (speed_zero && bus.park_req)   state_d = S_PARK;
      end
      S_CRUISE: begin
        if (obs_valid)                     state_d = S_EMERGENCY;
        else if (speed_zero)               state_d = S_PARK;
        else if (bus.speed < CRUISE_LO_V)  state_d = S_DRIVE;
      end
      S_REVERSE: begin
        if (obs_valid)                            state_d = S_EMERGENCY;
        else if (speed_zero && !bus.reverse_req)  state_d = S_PARK;
      end
      S_PARK: begin
        if (obs_valid)                         state_d = S_EMERGENCY;
        else if (!speed_zero && !bus.park_req) state_d = S_START;
      end
      S_EMERGENCY: begin
        if (!bus.obstacle && speed_zero && (hold_cnt_q == '0)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Saturating run-length of sampled-high obstacle; any low sample restarts qualification.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_cnt_q <= '0;
    end else if (!bus.obstacle) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q != FILT_MAX) begin
      filt_cnt_q <= filt_cnt_q + FILT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_q <= '0;
    end else if (entering_emg) begin
      hold_cnt_q <= HOLD_LOAD;
    end else if (state_q == S_EMERGENCY) begin
      if (bus.obstacle) begin
        hold_cnt_q <= HOLD_LOAD;
      end else if (hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
      end
    end
  end

  // The pulse is registered alongside the entry so the output stays Moore.
  always_ff @(posedge clk) begin
    if (reset) begin
      emg_cnt_q   <= '0;
      emg_first_q <= 1'b0;
    end else begin
      emg_first_q <= entering_emg;
      if (entering_emg && (emg_cnt_q != '1)) begin
        emg_cnt_q <= emg_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.accelerate = (state_q == S_DRIVE) || (state_q == S_CRUISE);
  assign bus.brake      = (state_q == S_PARK) || (state_q == S_EMERGENCY);
  assign bus.reverse_en = (state_q == S_REVERSE);
  assign bus.state      = state_q;
  assign bus.emergency  = emg_first_q;
  assign bus.emg_count  = emg_cnt_q;

endmodule

// File: tb/tb_drive_mode_ctrl_p.sv
// tb/tb_drive_mode_ctrl_p.sv - directed and randomized checks of drive_mode_ctrl_p against a behavioural model
module tb_drive_mode_ctrl_p;

  localparam int DRIVE_TH  = 10;
  localparam int CRUISE_TH = 30;
  localparam int HYST      = 5;
  localparam int OBS_FILT  = 3;
  localparam int EMG_HOLD  = 16;

  logic       clk;
  logic       reset;
  logic [7:0] speed;
  logic       obstacle;
  logic       reverse_req;
  logic       park_req;

  int n_checks;
  int n_errors;

  int m_state;
  int m_run;
  int m_quiet;
  int m_entries;
  int m_pulse;

  drive_mode_ctrl_p_if #(.SPEED_W(8), .CNT_W(8)) b1 ();
  drive_mode_ctrl_p_if #(.SPEED_W(8), .CNT_W(2)) b2 ();

  assign b1.speed       = speed;
  assign b1.obstacle    = obstacle;
  assign b1.reverse_req = reverse_req;
  assign b1.park_req    = park_req;
  assign b2.speed       = speed;
  assign b2.obstacle    = obstacle;
  assign b2.reverse_req = reverse_req;
  assign b2.park_req    = park_req;

  drive_mode_ctrl_p #(.SPEED_W(8), .DRIVE_TH(DRIVE_TH), .CRUISE_TH(CRUISE_TH), .HYST(HYST),
                      .OBS_FILT(OBS_FILT), .EMG_HOLD(EMG_HOLD), .CNT_W(8))
    dut (.clk(clk), .reset(reset), .bus(b1));

  drive_mode_ctrl_p #(.SPEED_W(8), .DRIVE_TH(DRIVE_TH), .CRUISE_TH(CRUISE_TH), .HYST(HYST),
                      .OBS_FILT(OBS_FILT), .EMG_HOLD(EMG_HOLD), .CNT_W(2))
    dut_small (.clk(clk), .reset(reset), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  // Model of the rules: run = consecutive sampled-high edges, quiet = obstacle-free edges since last hold load.
  task automatic model_step();
    int  ns;
    bit  ov;
    bit  entering;
    if (reset) begin
      m_state = 0; m_run = 0; m_quiet = 0; m_entries = 0; m_pulse = 0;
      return;
    end
    ov = obstacle && (m_run >= OBS_FILT - 1);
    ns = m_state;
    if (m_state >= 1 && m_state <= 5 && ov) ns = 6;
    else begin
      case (m_state)
        0: if (speed > 0) ns = 1;
        1: if (reverse_req) ns = 3; else if (speed >= DRIVE_TH) ns = 2;
        2: if (speed >= CRUISE_TH) ns = 4; else if (speed == 0 && park_req) ns = 5;
        4: if (speed == 0) ns = 5; else if (speed < CRUISE_TH - HYST) ns = 2;
        3: if (speed == 0 && !reverse_req) ns = 5;
        5: if (speed > 0 && !park_req) ns = 1;
        6: if (!obstacle && speed == 0 && m_quiet >= EMG_HOLD) ns = 0;
        default: ns = 0;
      endcase
    end
    entering = (ns == 6) && (m_state != 6);
    if (entering) m_quiet = 0;
    else if (m_state == 6) m_quiet = obstacle ? 0 : m_quiet + 1;
    m_pulse = entering ? 1 : 0;
    if (entering) m_entries++;
    m_run = obstacle ? m_run + 1 : 0;
    m_state = ns;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("state",      32'(b1.state),      32'(m_state));
    check("accelerate", 32'(b1.accelerate), 32'(m_state == 2 || m_state == 4));
    check("brake",      32'(b1.brake),      32'(m_state == 5 || m_state == 6));
    check("reverse_en", 32'(b1.reverse_en), 32'(m_state == 3));
    check("emergency",  32'(b1.emergency),  32'(m_pulse));
    check("emg_count",  32'(b1.emg_count),  32'(sat(m_entries, 255)));
    check("state_c2",   32'(b2.state),      32'(m_state));
    check("emg_count_c2", 32'(b2.emg_count), 32'(sat(m_entries, 3)));
  endtask

  task automatic set_in(input int sp, input bit ob, input bit rv, input bit pk);
    speed = 8'(sp); obstacle = ob; reverse_req = rv; park_req = pk;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (b1.state != 3'd0 && n < 100) begin
      cycle();
      n++;
    end
  endtask

  int n;
  int pulses;
  int speeds[12] = '{0, 3, 9, 10, 11, 24, 25, 26, 29, 30, 31, 200};

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1;
    set_in(0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    check("rst_state", 32'(b1.state), 0);
    check("rst_outs", {28'd0, b1.accelerate, b1.brake, b1.reverse_en, b1.emergency}, 0);
    check("rst_count", 32'(b1.emg_count), 0);

    // Speed ramp through the drive states, with cruise hysteresis.
    cycle();                  check("ramp_idle", 32'(b1.state), 0);
    set_in(5, 0, 0, 0);  cycle(); check("ramp_start", 32'(b1.state), 1);
    set_in(12, 0, 0, 0); cycle(); check("ramp_drive", 32'(b1.state), 2);
    set_in(35, 0, 0, 0); cycle(); check("ramp_cruise", 32'(b1.state), 4);
    set_in(27, 0, 0, 0); cycle(); check("hyst_hold", 32'(b1.state), 4);
    set_in(24, 0, 0, 0); cycle(); check("hyst_fall", 32'(b1.state), 2);
    check("accel_drive", 32'(b1.accelerate), 1);

    // Two-cycle burst must not qualify; three-cycle burst must.
    set_in(24, 1, 0, 0); cycle(); cycle();
    set_in(24, 0, 0, 0); cycle(); check("burst2_no_emg", 32'(b1.state), 2);
    set_in(24, 1, 0, 0); cycle(); cycle(); check("burst3_pre", 32'(b1.state), 2);
    cycle();
    check("emg_entry", 32'(b1.state), 6);
    check("emg_pulse", 32'(b1.emergency), 1);
    check("emg_cnt1", 32'(b1.emg_count), 1);
    check("emg_brake", 32'(b1.brake), 1);

    set_in(0, 0, 0, 0);
    pulses = 0;
    n = 0;
    while (b1.state != 3'd0 && n < 100) begin
      cycle();
      n++;
      if (b1.emergency) pulses++;
    end
    check("emg_dwell", 32'(n), 32'(EMG_HOLD + 1));
    check("emg_single_pulse", 32'(pulses), 0);

    // Blip mid-hold reloads the timer.
    set_in(5, 0, 0, 0); cycle(); check("blip_start", 32'(b1.state), 1);
    set_in(5, 1, 0, 0); cycle(); cycle(); cycle(); check("blip_entry", 32'(b1.state), 6);
    set_in(0, 0, 0, 0); repeat (5) cycle();
    set_in(0, 1, 0, 0); cycle();
    set_in(0, 0, 0, 0);
    wait_idle(n);
    check("blip_dwell", 32'(n), 32'(EMG_HOLD + 1));

    // Reverse beats speed threshold in START, then park, then restart.
    set_in(5, 0, 0, 0);  cycle(); check("rev_start", 32'(b1.state), 1);
    set_in(15, 0, 1, 0); cycle(); check("rev_state", 32'(b1.state), 3);
    check("rev_en", 32'(b1.reverse_en), 1);
    set_in(0, 0, 0, 0);  cycle(); check("park_state", 32'(b1.state), 5);
    check("park_brake", 32'(b1.brake), 1);
    set_in(3, 0, 0, 0);  cycle(); check("park_restart", 32'(b1.state), 1);

    // Reset in CRUISE while the obstacle is qualifying.
    set_in(12, 0, 0, 0); cycle();
    set_in(35, 0, 0, 0); cycle(); check("pre_rst_cruise", 32'(b1.state), 4);
    set_in(35, 1, 0, 0); cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    check("midrst_state", 32'(b1.state), 0);
    check("midrst_outs", {28'd0, b1.accelerate, b1.brake, b1.reverse_en, b1.emergency}, 0);
    check("midrst_count", 32'(b1.emg_count), 0);

    // Saturation of the narrow counter over five entries.
    for (int i = 1; i <= 5; i++) begin
      set_in(5, 0, 0, 0); cycle();
      set_in(5, 1, 0, 0); cycle(); cycle(); cycle();
      check("sat_small_cnt", 32'(b2.emg_count), 32'(i < 3 ? i : 3));
      check("sat_wide_cnt", 32'(b1.emg_count), 32'(i));
      set_in(0, 0, 0, 0);
      wait_idle(n);
      check("sat_exit", 32'(b1.state), 0);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) speed = 8'(speeds[$urandom_range(0, 11)]);
      obstacle    = ($urandom_range(0, 9) < 3);
      reverse_req = ($urandom_range(0, 5) == 0);
      park_req    = ($urandom_range(0, 2) == 0);
      reset       = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
